// File: rtl/zpu_defines.sv
// Shared constants, types and address decode for the ZPU memory responder.
// Holds the I/O address map, CON_STAT bit layout and the access state machine encoding.
package zpu_defines;

  localparam logic [31:0] CON_DATA_ADDR = 32'h8000_0000;
  localparam logic [31:0] CON_STAT_ADDR = 32'h8000_0004;
  localparam logic [31:0] CYCLES_ADDR   = 32'h8000_0008;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_STALL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    RGN_RAM      = 3'd0,
    RGN_CON_DATA = 3'd1,
    RGN_CON_STAT = 3'd2,
    RGN_CYCLES   = 3'd3,
    RGN_NONE     = 3'd4
  } region_t;

  // Byte-lane bits are ignored; any I/O word outside the three registers is unmapped.
  function automatic region_t decode_region(input logic [31:0] addr);
    logic [31:0] word_addr;
    word_addr = {addr[31:2], 2'b00};
    if (!addr[31])                       return RGN_RAM;
    else if (word_addr == CON_DATA_ADDR) return RGN_CON_DATA;
    else if (word_addr == CON_STAT_ADDR) return RGN_CON_STAT;
    else if (word_addr == CYCLES_ADDR)   return RGN_CYCLES;
    else                                 return RGN_NONE;
  endfunction

endpackage

// File: rtl/zpu_byte_fifo.sv
// Console byte FIFO: power-of-two depth, head shown combinationally, zero when empty.
// A push is taken when full if a pop happens in the same cycle.
module zpu_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [7:0]                 i_data,
  input  logic                       i_pop,
  output logic [7:0]                 o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    r_mem [0:DEPTH-1];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_count   = r_count;
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == {CW{1'b0}});
  assign o_data    = o_empty ? 8'h00 : r_mem[r_rd];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd    <= {PW{1'b0}};
      r_wr    <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset && w_do_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/zpu_mem_responder.sv
// Wait-stated memory responder for a ZPU core: word RAM plus console FIFO and cycle counter.
// Every access completes with a one-cycle o_done; console writes stall while the FIFO is full.
module zpu_mem_responder
  import zpu_defines::*;
#(
  parameter int ADDR_W = 12,
  parameter int WAIT   = 2,
  parameter int FIFO_D = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_read,
  input  logic        i_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data_write,
  output logic [31:0] o_data_read,
  output logic        o_done,
  output logic        o_con_valid,
  output logic [7:0]  o_con_data,
  input  logic        i_con_ready,
  output logic        o_err
);
  localparam int CNT_W = 4;
  localparam int FC_W  = $clog2(FIFO_D) + 1;

  state_t            r_state, w_state_nx;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
  region_t           r_rgn;
  logic              r_is_read, r_is_write;
  logic [ADDR_W-1:0] r_word;
  logic [31:0]       r_wdata, r_cycles, r_data_read;
  logic              r_done, r_err;
  logic [31:0]       r_ram [0:(1<<ADDR_W)-1];

  logic              w_req, w_new_con_wr, w_con_wr, w_full, w_empty, w_push;
  logic [FC_W-1:0]   w_count;
  logic [31:0]       w_stat, w_rd_value;
  state_t            w_expire_st;

  assign w_req        = i_read | i_write;
  assign w_new_con_wr = i_write & ~i_read & (decode_region(i_addr) == RGN_CON_DATA);
  assign w_con_wr     = r_is_write & (r_rgn == RGN_CON_DATA);
  assign w_expire_st  = (w_con_wr && w_full) ? ST_STALL : ST_DONE;
  assign w_push       = (r_state == ST_DONE) & w_con_wr;
  assign w_stat       = {16'h0000, 8'(w_count), 6'b000000, w_empty, w_full};

  // Next-state logic; the counter is loaded on acceptance and expires at 1.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (WAIT == 32'sd0) begin
            w_state_nx = (w_new_con_wr && w_full) ? ST_STALL : ST_DONE;
          end else begin
            w_state_nx = ST_WAIT;
            w_cnt_nx   = CNT_W'(WAIT);
          end
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt <= 4'd1) w_state_nx = w_expire_st;
        else               w_cnt_nx   = r_cnt - 4'd1;
      end
      ST_STALL: begin
        if (!w_full) w_state_nx = ST_DONE;
        else         w_state_nx = ST_STALL;
      end
      ST_DONE: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // A simultaneous read+write latches as neither, so it completes with no effect.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rgn      <= RGN_NONE;
      r_is_read  <= 1'b0;
      r_is_write <= 1'b0;
      r_word     <= {ADDR_W{1'b0}};
      r_wdata    <= 32'h0000_0000;
    end else if (r_state == ST_IDLE && w_req) begin
      r_rgn      <= decode_region(i_addr);
      r_is_read  <= i_read & ~i_write;
      r_is_write <= i_write & ~i_read;
      r_word     <= i_addr[ADDR_W+1:2];
      r_wdata    <= i_data_write;
    end
  end

  always_comb begin
    w_rd_value = 32'h0000_0000;
    if (r_is_read) begin
      case (r_rgn)
        RGN_RAM:      w_rd_value = r_ram[r_word];
        RGN_CON_STAT: w_rd_value = w_stat;
        RGN_CYCLES:   w_rd_value = r_cycles;
        default:      w_rd_value = 32'h0000_0000;
      endcase
    end else begin
      w_rd_value = 32'h0000_0000;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_done      <= 1'b0;
      r_data_read <= 32'h0000_0000;
      r_err       <= 1'b0;
      r_cycles    <= 32'h0000_0000;
    end else begin
      r_cycles <= r_cycles + 32'd1;
      r_done   <= (r_state == ST_DONE);
      if (r_state == ST_DONE) r_data_read <= w_rd_value;
      if (w_req && (r_state != ST_IDLE || (i_read && i_write))) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && r_state == ST_DONE && r_is_write && r_rgn == RGN_RAM) r_ram[r_word] <= r_wdata;
  end

  zpu_byte_fifo #(.DEPTH(FIFO_D)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (r_wdata[7:0]),
    .i_pop   (i_con_ready),
    .o_data  (o_con_data),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_con_valid = ~w_empty;
  assign o_done      = r_done;
  assign o_data_read = r_data_read;
  assign o_err       = r_err;

endmodule

// File: tb/tb_zpu_mem_responder.sv
// Directed bench for zpu_mem_responder: one instance with WAIT=2, one with WAIT=0.
module tb_zpu_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, rd, wr, con_ready;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        done, con_valid, err;
  logic [7:0]  con_data;

  logic        reset0, rd0, wr0, con_ready0;
  logic [31:0] addr0, wdata0;
  logic [31:0] rdata0;
  logic        done0, con_valid0, err0;
  logic [7:0]  con_data0;

  int checks = 0;
  int errors = 0;

  zpu_mem_responder #(.ADDR_W(12), .WAIT(2), .FIFO_D(4)) u_dut (
    .clk(clk), .reset(reset), .i_read(rd), .i_write(wr), .i_addr(addr),
    .i_data_write(wdata), .o_data_read(rdata), .o_done(done),
    .o_con_valid(con_valid), .o_con_data(con_data), .i_con_ready(con_ready), .o_err(err)
  );

  zpu_mem_responder #(.ADDR_W(12), .WAIT(0), .FIFO_D(4)) u_dut0 (
    .clk(clk), .reset(reset0), .i_read(rd0), .i_write(wr0), .i_addr(addr0),
    .i_data_write(wdata0), .o_data_read(rdata0), .o_done(done0),
    .o_con_valid(con_valid0), .o_con_data(con_data0), .i_con_ready(con_ready0), .o_err(err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where o_done is seen (lat = edges after the request edge).
  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] q);
    rd = r; wr = w; addr = a; wdata = d;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0; lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    q = rdata;
  endtask

  task automatic access0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] q);
    rd0 = r; wr0 = w; addr0 = a; wdata0 = d;
    @(negedge clk);
    rd0 = 1'b0; wr0 = 1'b0; lat = 0;
    while (done0 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    q = rdata0;
  endtask

  initial begin
    int          lat, dn;
    logic [31:0] q, v1;
    logic [7:0]  got[$];
    logic [7:0]  exp_bytes[5];
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0; con_ready = 1'b0;
    reset0 = 1'b0; rd0 = 1'b0; wr0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0; con_ready0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_con_valid", 32'(con_valid), 32'd0);
    chk("rst_con_data", 32'(con_data), 32'd0);
    reset = 1'b1; reset0 = 1'b1;

    // WAIT=2: write then read back, latency 3 each
    access(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, lat, q);
    chk("wr100_lat", 32'(lat), 32'd3);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    access(1'b1, 1'b0, 32'h100, 32'h0, lat, q);
    chk("rd100_lat", 32'(lat), 32'd3);
    chk("rd100_data", q, 32'hDEADBEEF);
    access(1'b0, 1'b1, 32'h104, 32'h12345678, lat, q);
    access(1'b1, 1'b0, 32'h104, 32'h0, lat, q);
    chk("rd104_data", q, 32'h12345678);
    access(1'b1, 1'b0, 32'h0000_4100, 32'h0, lat, q);
    chk("rd_alias", q, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h103, 32'h0, lat, q);
    chk("rd_bytelane", q, 32'hDEADBEEF);

    // unmapped I/O, console data read, empty status
    access(1'b0, 1'b1, 32'h8000_0010, 32'hFFFFFFFF, lat, q);
    chk("unmap_wr_lat", 32'(lat), 32'd3);
    access(1'b1, 1'b0, 32'h8000_0010, 32'h0, lat, q);
    chk("unmap_rd_data", q, 32'h0);
    chk("unmap_err", 32'(err), 32'd0);
    access(1'b1, 1'b0, 32'h8000_0000, 32'h0, lat, q);
    chk("condata_rd", q, 32'h0);
    access(1'b1, 1'b0, 32'h8000_0004, 32'h0, lat, q);
    chk("stat_empty", q, 32'h0000_0002);

    // CYCLES: consecutive reads 4 edges apart; writes discarded
    access(1'b1, 1'b0, 32'h8000_0008, 32'h0, lat, v1);
    access(1'b1, 1'b0, 32'h8000_0008, 32'h0, lat, q);
    chk("cycles_delta", q - v1, 32'd4);
    access(1'b0, 1'b1, 32'h8000_0008, 32'hF000_0000, lat, q);
    chk("cycles_wr_lat", 32'(lat), 32'd3);
    access(1'b1, 1'b0, 32'h8000_0008, 32'h0, lat, q);
    chk("cycles_wr_discard", 32'(q < 32'h0001_0000), 32'd1);

    // WAIT=0: writes then back-to-back reads
    access0(1'b0, 1'b1, 32'h0, 32'hA5A5_0000, lat, q);
    chk("w0_wr_lat", 32'(lat), 32'd1);
    access0(1'b0, 1'b1, 32'h4, 32'h5A5A_0004, lat, q);
    access0(1'b1, 1'b0, 32'h0, 32'h0, lat, q);
    chk("w0_rd0_lat", 32'(lat), 32'd1);
    chk("w0_rd0_data", q, 32'hA5A5_0000);
    access0(1'b1, 1'b0, 32'h4, 32'h0, lat, q);
    chk("w0_rd4_lat", 32'(lat), 32'd1);
    chk("w0_rd4_data", q, 32'h5A5A_0004);
    chk("w0_no_err", 32'(err0), 32'd0);
    // request during DONE is ignored and flagged
    rd0 = 1'b1; addr0 = 32'h0;
    @(negedge clk);
    addr0 = 32'h4;
    @(negedge clk);
    rd0 = 1'b0;
    chk("w0_busy_done", 32'(done0), 32'd1);
    chk("w0_busy_data", rdata0, 32'hA5A5_0000);
    @(negedge clk);
    chk("w0_busy_ignored", 32'(done0), 32'd0);
    chk("w0_busy_err", 32'(err0), 32'd1);

    // console: fill FIFO with sink stalled
    access(1'b0, 1'b1, 32'h8000_0000, 32'hAAAA_AA11, lat, q);
    chk("con1_lat", 32'(lat), 32'd3);
    access(1'b0, 1'b1, 32'h8000_0000, 32'hAAAA_AA22, lat, q);
    access(1'b0, 1'b1, 32'h8000_0000, 32'hAAAA_AA33, lat, q);
    access(1'b0, 1'b1, 32'h8000_0000, 32'hAAAA_AA44, lat, q);
    chk("con4_lat", 32'(lat), 32'd3);
    access(1'b1, 1'b0, 32'h8000_0004, 32'h0, lat, q);
    chk("stat_full", q, 32'h0000_0401);
    chk("con_head", 32'(con_data), 32'h11);
    rd = 1'b0; wr = 1'b1; addr = 32'h8000_0000; wdata = 32'h0000_0055;
    @(negedge clk);
    wr = 1'b0; dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("con5_stalls", 32'(dn), 32'd0);
    con_ready = 1'b1; dn = 0;
    for (int i = 0; i < 20; i++) begin
      if (con_valid && con_ready) got.push_back(con_data);
      if (done) dn++;
      @(negedge clk);
    end
    con_ready = 1'b0;
    chk("con5_done", 32'(dn), 32'd1);
    chk("con_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) chk($sformatf("con_byte%0d", i), 32'(got[i]), 32'(exp_bytes[i]));
      else chk($sformatf("con_byte%0d_missing", i), 32'd1, 32'd0);
    end

    // simultaneous read+write is an error with no write
    access(1'b1, 1'b1, 32'h100, 32'hCAFEF00D, lat, q);
    chk("rw_lat", 32'(lat), 32'd3);
    chk("rw_data", q, 32'h0);
    chk("rw_err", 32'(err), 32'd1);
    access(1'b1, 1'b0, 32'h100, 32'h0, lat, q);
    chk("rw_ram_kept", q, 32'hDEADBEEF);

    // reset during WAIT of a write aborts it
    rd = 1'b0; wr = 1'b1; addr = 32'h100; wdata = 32'h0BADF00D;
    @(negedge clk);
    wr = 1'b0; reset = 1'b0; dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    chk("abort_err_clr", 32'(err), 32'd0);
    chk("abort_rdata_clr", rdata, 32'h0);
    reset = 1'b1;
    access(1'b1, 1'b0, 32'h8000_0008, 32'h0, lat, q);
    chk("abort_cycles", q, 32'd3);
    access(1'b1, 1'b0, 32'h100, 32'h0, lat, q);
    chk("abort_ram_old", q, 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zpu_mem_responder.md
ZPU_MEM_RESPONDER -- requirements
Module: zpu_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: RAM word-address bits (4 Ki words).
REQ-002 SHALL have parameter WAIT, default 2: wait states per access, legal range 0..15.
REQ-003 SHALL have parameter FIFO_D, default 4: console FIFO depth, power of two.
REQ-004 SHALL have port clk  in  1: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1: synchronous, active-low reset (0 = reset).
REQ-006 SHALL have port i_read  in  1: read request, one-cycle pulse from the CPU.
REQ-007 SHALL have port i_write  in  1: write request, one-cycle pulse from the CPU.
REQ-008 SHALL have port i_addr  in  32: byte address; bits [1:0] ignored.
REQ-009 SHALL have port i_data_write  in  32: write data, sampled with the request.
REQ-010 SHALL have port o_data_read  out  32: read data, valid while o_done is 1.
REQ-011 SHALL have port o_done  out  1: one-cycle completion pulse.
REQ-012 SHALL have port o_con_valid  out  1: console byte available.
REQ-013 SHALL have port o_con_data  out  8: console byte (FIFO head).
REQ-014 SHALL have port i_con_ready  in  1: console sink accepts the byte when o_con_valid and i_con_ready are both 1.
REQ-015 SHALL have port o_err  out  1: sticky protocol-error flag.

Function
REQ-016 SHALL decode the address map as follows: i_addr[31]=0 selects RAM word i_addr[ADDR_W+1:2], with upper bits aliasing; 0x8000_0000 is CON_DATA; 0x8000_0004 is CON_STAT; 0x8000_0008 is CYCLES.
REQ-017 SHALL run a state machine with states IDLE, WAIT, STALL and DONE; a request is sampled only in IDLE.
REQ-018 SHALL, when IDLE samples a request, latch the address and data and go to WAIT with counter=WAIT, or go straight to DONE if WAIT=0.
REQ-019 SHALL decrement the counter in WAIT and go to DONE when it reaches 1; o_done SHALL be high exactly WAIT+1 cycles after the request edge.
REQ-020 SHALL assert o_done for one cycle in DONE and then return to IDLE; a new request is accepted in the cycle after DONE.
REQ-021 SHALL perform RAM writes in the DONE cycle; RAM reads SHALL return the latched word, and o_data_read SHALL hold its value until the next DONE.
REQ-022 SHALL, for a CON_DATA write with the FIFO full when WAIT expires, enter STALL and hold there (o_done=0) until a slot frees, then push the byte i_data_write[7:0] and enter DONE.
REQ-023 SHALL return {16'b0, count[7:0], 6'b0, empty, full} on a CON_STAT read, and 0 on a CON_DATA read.
REQ-024 SHALL keep CYCLES as a 32-bit free-running counter that wraps 0xFFFF_FFFF -> 0; it is read-only, and writes to it are completed but discarded.
REQ-025 SHALL pop the FIFO on o_con_valid & i_con_ready; a push and a pop in the same cycle SHALL leave the count unchanged, which is legal even when the FIFO is full.
REQ-026 SHALL, when i_read and i_write are both 1, treat the request as an error: set o_err, complete normally with no write and o_data_read=0.
REQ-027 SHALL, on a request while not IDLE, ignore the request and set o_err.
REQ-028 SHALL, on an access to an unmapped I/O address, complete normally, discard writes, return 0 and leave o_err unchanged.

Reset
REQ-029 SHALL, while reset=0, force: state IDLE, o_done=0, o_data_read=0, o_err=0, FIFO empty (o_con_valid=0), o_con_data=0, CYCLES=0.
REQ-030 SHALL abort any access in progress when reset asserts mid-operation: no o_done and no RAM or FIFO write.
REQ-031 SHALL leave RAM contents unaffected by reset.

Structure
REQ-032 SHALL place the address constants, CON_STAT bit positions and the state enum in the shared zpu_defines package.
REQ-033 SHALL implement the console FIFO as a sub-module zpu_byte_fifo (push, pop, count, full, empty).

Verification
REQ-034 SHALL verify, with WAIT=2: write 0xDEADBEEF to 0x100, then read 0x100 -> o_done 3 cycles after each request, and o_data_read=0xDEADBEEF.
REQ-035 SHALL verify, with WAIT=0: back-to-back reads of 0x0 and 0x4 -> each o_done 1 cycle after its request, with no lost request.
REQ-036 SHALL verify, with i_con_ready=0: 5 writes to CON_DATA -> the 4 FIFO-fitting writes complete and the 5th stalls; raising i_con_ready completes the 5th, and bytes emerge in order.
REQ-037 SHALL verify: a CON_STAT read with the FIFO full -> 0x0000_0401.
REQ-038 SHALL verify: i_read=i_write=1 to 0x100 -> o_done, o_data_read=0, o_err=1, and RAM[0x40] unchanged.
REQ-039 SHALL verify: reset=0 during WAIT of a write -> no o_done; a later read returns the old data and CYCLES restarts from 0.
